// File: rtl/ps2_key_tracker_if.sv
// Byte-stream input and key-event output bundle for the PS/2 key tracker.
// The master side feeds received bytes; the slave side (the tracker) drives events and display state.
interface ps2_key_tracker_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic [7:0]       key_code;
  logic             key_ext;
  logic [7:0]       key_ascii;
  logic             rel;
  logic [CNT_W-1:0] press_cnt;
  logic             evt_valid;
  logic             evt_break;
  logic             evt_rpt;
  logic             proto_err;

  modport master (
    output in_valid, in_data,
    input  key_code, key_ext, key_ascii, rel, press_cnt,
    input  evt_valid, evt_break, evt_rpt, proto_err
  );

  modport slave (
    input  in_valid, in_data,
    output key_code, key_ext, key_ascii, rel, press_cnt,
    output evt_valid, evt_break, evt_rpt, proto_err
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// Turns PS/2 set-2 bytes into make/break/repeat events; outputs register at the edge sampling
// the final byte of a sequence. Every byte is consumed in one cycle, no backpressure.
module ps2_key_tracker #(
  parameter int CNT_W     = 16,
  parameter int PREFIX_TO = 65535
) (
  input logic             clk,
  input logic             clr,
  ps2_key_tracker_if.slave bus
);
  localparam int TO_W = $clog2(PREFIX_TO + 1);

  typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

  state_t           r_state, w_state;
  logic [TO_W-1:0]  r_to, w_to;
  logic [7:0]       r_code, w_code, r_ascii, w_ascii;
  logic             r_ext, w_ext, r_rel, w_rel;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_evt, w_evt, r_brk, w_brk, r_rpt, w_rpt, r_err, w_err;
  logic             w_make, w_break, w_seq_ext, w_hit;

  function automatic logic [7:0] f_ascii(input logic [7:0] c);
    case (c)
      8'h1C: f_ascii = "a"; 8'h32: f_ascii = "b"; 8'h21: f_ascii = "c"; 8'h23: f_ascii = "d";
      8'h24: f_ascii = "e"; 8'h2B: f_ascii = "f"; 8'h34: f_ascii = "g"; 8'h33: f_ascii = "h";
      8'h43: f_ascii = "i"; 8'h3B: f_ascii = "j"; 8'h42: f_ascii = "k"; 8'h4B: f_ascii = "l";
      8'h3A: f_ascii = "m"; 8'h31: f_ascii = "n"; 8'h44: f_ascii = "o"; 8'h4D: f_ascii = "p";
      8'h15: f_ascii = "q"; 8'h2D: f_ascii = "r"; 8'h1B: f_ascii = "s"; 8'h2C: f_ascii = "t";
      8'h3C: f_ascii = "u"; 8'h2A: f_ascii = "v"; 8'h1D: f_ascii = "w"; 8'h22: f_ascii = "x";
      8'h35: f_ascii = "y"; 8'h1A: f_ascii = "z";
      8'h45: f_ascii = "0"; 8'h16: f_ascii = "1"; 8'h1E: f_ascii = "2"; 8'h26: f_ascii = "3";
      8'h25: f_ascii = "4"; 8'h2E: f_ascii = "5"; 8'h36: f_ascii = "6"; 8'h3D: f_ascii = "7";
      8'h3E: f_ascii = "8"; 8'h46: f_ascii = "9";
      8'h29: f_ascii = 8'h20;
      8'h5A: f_ascii = 8'h0D;
      default: f_ascii = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_to    <= '0;
      r_code  <= 8'h00;
      r_ext   <= 1'b0;
      r_ascii <= 8'h00;
      r_rel   <= 1'b1;
      r_cnt   <= '0;
      r_evt   <= 1'b0;
      r_brk   <= 1'b0;
      r_rpt   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_to    <= w_to;
      r_code  <= w_code;
      r_ext   <= w_ext;
      r_ascii <= w_ascii;
      r_rel   <= w_rel;
      r_cnt   <= w_cnt;
      r_evt   <= w_evt;
      r_brk   <= w_brk;
      r_rpt   <= w_rpt;
      r_err   <= w_err;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_to      = '0;
    w_code    = r_code;
    w_ext     = r_ext;
    w_ascii   = r_ascii;
    w_rel     = r_rel;
    w_cnt     = r_cnt;
    w_evt     = 1'b0;
    w_brk     = 1'b0;
    w_rpt     = 1'b0;
    w_err     = 1'b0;
    w_make    = 1'b0;
    w_break   = 1'b0;
    w_seq_ext = (r_state == S_E0) || (r_state == S_E0F0);

    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_data == 8'hE0) w_state = S_E0;
          else if (bus.in_data == 8'hF0) w_state = S_F0;
          else if (!(bus.in_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}))
            w_make = 1'b1;
        end
      end
      S_E0: begin
        if (bus.in_valid) begin
          if (bus.in_data == 8'hF0) w_state = S_E0F0;
          else if (bus.in_data != 8'hE0) begin
            w_make  = 1'b1;
            w_state = S_IDLE;
          end
        end
      end
      default: begin
        if (bus.in_valid) begin
          w_state = S_IDLE;
          if (bus.in_data == 8'hE0 || bus.in_data == 8'hF0) w_err = 1'b1;
          else w_break = 1'b1;
        end
      end
    endcase

    // Prefix timeout only runs while waiting for the rest of a sequence with no byte arriving.
    if (r_state != S_IDLE && !bus.in_valid) begin
      if (r_to == TO_W'(PREFIX_TO - 1)) begin
        w_err   = 1'b1;
        w_state = S_IDLE;
      end else begin
        w_to = r_to + 1'b1;
      end
    end

    w_hit = !r_rel && (w_seq_ext == r_ext) && (bus.in_data == r_code);

    if (w_make) begin
      w_evt = 1'b1;
      if (w_hit) begin
        w_rpt = 1'b1;
      end else begin
        w_code  = bus.in_data;
        w_ext   = w_seq_ext;
        w_ascii = w_seq_ext ? 8'h00 : f_ascii(bus.in_data);
        w_rel   = 1'b0;
        w_cnt   = r_cnt + 1'b1;
      end
    end

    if (w_break) begin
      w_evt = 1'b1;
      w_brk = 1'b1;
      if (w_hit) w_rel = 1'b1;
    end
  end

  assign bus.key_code  = r_code;
  assign bus.key_ext   = r_ext;
  assign bus.key_ascii = r_ascii;
  assign bus.rel       = r_rel;
  assign bus.press_cnt = r_cnt;
  assign bus.evt_valid = r_evt;
  assign bus.evt_break = r_brk;
  assign bus.evt_rpt   = r_rpt;
  assign bus.proto_err = r_err;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed and random byte streams into ps2_key_tracker, checked every cycle against a
// queue-based model of the prefix rules and a table-driven ASCII map.
module tb_ps2_key_tracker;
  localparam int CNT_W = 4;
  localparam int TO    = 8;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  ps2_key_tracker_if #(.CNT_W(CNT_W)) bus ();
  ps2_key_tracker #(.CNT_W(CNT_W), .PREFIX_TO(TO)) dut (.clk(clk), .clr(clr), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] ascii_tab [256];
  logic [7:0] pend [$];
  int         gap;
  bit         m_held, m_ext;
  logic [7:0] m_code, m_ascii;
  int         m_cnt;
  bit         e_vld, e_brk, e_rpt, e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_table();
    string      letters = "abcdefghijklmnopqrstuvwxyz";
    logic [7:0] lc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                            8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                            8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 256; i++) ascii_tab[i] = 8'h00;
    for (int i = 0; i < 26; i++) ascii_tab[lc[i]] = letters[i];
    for (int i = 0; i < 10; i++) ascii_tab[dc[i]] = 8'h30 + 8'(i);
    ascii_tab[8'h29] = 8'h20;
    ascii_tab[8'h5A] = 8'h0D;
  endtask

  function automatic bit in_pend(input logic [7:0] b);
    foreach (pend[i]) if (pend[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_tick(input bit v, input logic [7:0] b, input bit c);
    bit has_e0, has_f0;
    e_vld = 0; e_brk = 0; e_rpt = 0; e_err = 0;
    if (!c) begin
      pend.delete(); gap = 0; m_held = 0; m_ext = 0;
      m_code = 0; m_ascii = 0; m_cnt = 0;
      return;
    end
    if (!v) begin
      if (pend.size() > 0) begin
        gap++;
        if (gap == TO) begin e_err = 1; pend.delete(); gap = 0; end
      end
      return;
    end
    gap = 0;
    has_e0 = in_pend(8'hE0);
    has_f0 = in_pend(8'hF0);
    if (b == 8'hE0 || b == 8'hF0) begin
      if (has_f0) begin e_err = 1; pend.delete(); end
      else if (!(b == 8'hE0 && has_e0)) pend.push_back(b);
    end else if (pend.size() == 0 && b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) begin
    end else begin
      pend.delete();
      e_vld = 1;
      if (has_f0) begin
        e_brk = 1;
        if (m_held && m_ext == has_e0 && m_code == b) m_held = 0;
      end else if (m_held && m_ext == has_e0 && m_code == b) begin
        e_rpt = 1;
      end else begin
        m_held  = 1;
        m_ext   = has_e0;
        m_code  = b;
        m_ascii = has_e0 ? 8'h00 : ascii_tab[b];
        m_cnt   = (m_cnt + 1) % (1 << CNT_W);
      end
    end
  endtask

  task automatic check_all();
    chk("key_code",  {24'h0, bus.key_code},  {24'h0, m_code});
    chk("key_ext",   {31'h0, bus.key_ext},   {31'h0, m_ext});
    chk("key_ascii", {24'h0, bus.key_ascii}, {24'h0, m_ascii});
    chk("rel",       {31'h0, bus.rel},       {31'h0, !m_held});
    chk("press_cnt", 32'(bus.press_cnt),     32'(m_cnt));
    chk("evt_valid", {31'h0, bus.evt_valid}, {31'h0, e_vld});
    chk("evt_break", {31'h0, bus.evt_break}, {31'h0, e_brk});
    chk("evt_rpt",   {31'h0, bus.evt_rpt},   {31'h0, e_rpt});
    chk("proto_err", {31'h0, bus.proto_err}, {31'h0, e_err});
  endtask

  task automatic step(input bit v, input logic [7:0] b);
    bus.in_valid = v;
    bus.in_data  = b;
    @(posedge clk);
    #1;
    model_tick(v, b, clr);
    check_all();
    bus.in_valid = 1'b0;
  endtask

  task automatic byte_in(input logic [7:0] b);
    step(1'b1, b);
  endtask

  logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h1C, 8'h32, 8'h75, 8'h29, 8'h5A, 8'h45,
                            8'hAA, 8'h00, 8'h6B, 8'hE0};

  initial begin
    build_table();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    clr = 1'b0;
    step(0, 8'h00);
    step(1, 8'h1C);
    chk("reset_cnt", 32'(bus.press_cnt), 32'd0);
    chk("reset_rel", {31'h0, bus.rel}, 32'd1);
    clr = 1'b1;

    byte_in(8'h1C);
    chk("t1_ascii", {24'h0, bus.key_ascii}, 32'h61);
    chk("t1_cnt", 32'(bus.press_cnt), 32'd1);
    byte_in(8'h1C);
    byte_in(8'h1C);
    chk("t2_rpt", {31'h0, bus.evt_rpt}, 32'd1);
    chk("t2_cnt", 32'(bus.press_cnt), 32'd1);
    byte_in(8'hF0); byte_in(8'h1C);
    chk("t2_rel", {31'h0, bus.rel}, 32'd1);
    chk("t2_brk", {31'h0, bus.evt_break}, 32'd1);

    byte_in(8'hE0); byte_in(8'h75);
    chk("t3_ext", {31'h0, bus.key_ext}, 32'd1);
    chk("t3_cnt", 32'(bus.press_cnt), 32'd2);
    byte_in(8'hE0); byte_in(8'hF0); byte_in(8'h75);
    chk("t3_rel", {31'h0, bus.rel}, 32'd1);
    byte_in(8'hE0); byte_in(8'h75);
    byte_in(8'hF0); byte_in(8'h75);
    chk("t3_nonext_brk", {31'h0, bus.rel}, 32'd0);

    byte_in(8'h1C); byte_in(8'h32);
    chk("t4_ascii", {24'h0, bus.key_ascii}, 32'h62);
    chk("t4_cnt", 32'(bus.press_cnt), 32'd5);
    byte_in(8'hF0); byte_in(8'h1C);
    chk("t4_rel0", {31'h0, bus.rel}, 32'd0);
    byte_in(8'hF0); byte_in(8'h32);
    chk("t4_rel1", {31'h0, bus.rel}, 32'd1);

    byte_in(8'hF0);
    clr = 1'b0; step(0, 8'h00); clr = 1'b1;
    byte_in(8'h1C);
    chk("t5_make", {31'h0, bus.rel}, 32'd0);
    chk("t5_cnt", 32'(bus.press_cnt), 32'd1);
    byte_in(8'hF0); byte_in(8'hF0);
    chk("t5_err", {31'h0, bus.proto_err}, 32'd1);

    byte_in(8'hE0);
    for (int i = 0; i < TO; i++) step(0, 8'h00);
    chk("t6_to", {31'h0, bus.proto_err}, 32'd1);
    byte_in(8'h75);
    chk("t6_ext", {31'h0, bus.key_ext}, 32'd0);

    clr = 1'b0; step(0, 8'h00); clr = 1'b1;
    for (int i = 0; i < 16; i++) byte_in((i % 2 == 0) ? 8'h1C : 8'h32);
    chk("t7_wrap", 32'(bus.press_cnt), 32'd0);

    for (int n = 0; n < 2500; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 3) begin
        clr = 1'b0; step(0, 8'h00); clr = 1'b1;
      end else if (r < 25) begin
        step(0, 8'h00);
      end else if (r < 30) begin
        for (int k = 0; k < $urandom_range(5, 10); k++) step(0, 8'h00);
      end else if (r < 40) begin
        byte_in(8'($urandom_range(0, 255)));
      end else begin
        byte_in(pool[$urandom_range(0, 11)]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
